// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: FSM encoding, access types, abort data.
// No logic; imported by dmem_bridge and dmem_req_reg.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MEMACC_LOAD  = 1'b0;
    localparam logic MEMACC_STORE = 1'b1;

    // Returned to the core on an aborted load so the failure is visible in the data too.
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_req_reg.sv
// Capture register for the outgoing bus request (addr, wdata, we).
// Latency: one cycle from load to outputs.
// Backpressure: none; holds its value until the next load, so bus fields stay stable while stalled.
module dmem_req_reg
    import dmem_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] addr_d,
    input  logic [DATA_W-1:0] wdata_d,
    input  logic              type_d,
    output logic [ADDR_W-1:0] addr_q,
    output logic [DATA_W-1:0] wdata_q,
    output logic              we_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (load) begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= (type_d == MEMACC_STORE);
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the core's single-cycle data access to a valid/ready request + response-pulse bus.
// Latency: accept->REQ->WAIT->DONE, 3 cycles minimum; stall held high while the access is in flight.
// Backpressure: request held stable until bus_req_ready; optional abort via DMEM_TIMEOUT_EN.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic              core_type,
    input  logic              core_valid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    output logic              core_err,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_req_we,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic [DATA_W-1:0] bus_req_wdata,
    input  logic              bus_rsp_valid,
    input  logic [DATA_W-1:0] bus_rsp_data
);

    state_t state, state_nxt;

    logic aligned;
    logic accept;
    logic load_req;
    logic rsp_take;
    logic timeout_hit;
    logic timeout_abort;
    logic misalign_err;

    assign aligned = (core_addr[1:0] == 2'b00);

    dmem_req_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_req_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (load_req),
        .addr_d  (core_addr),
        .wdata_d (core_wdata),
        .type_d  (core_type),
        .addr_q  (bus_req_addr),
        .wdata_q (bus_req_wdata),
        .we_q    (bus_req_we)
    );

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] to_cnt;
    logic [CNT_W-1:0] to_cnt_inc;

    assign to_cnt_inc  = to_cnt + 1'b1;
    assign timeout_hit = ((state == REQ) || (state == WAIT)) && (to_cnt_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (load_req) begin
            to_cnt <= '0;
        end else if ((state == REQ) || (state == WAIT)) begin
            to_cnt <= to_cnt_inc;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // A response arriving in the same cycle as the timeout completes normally.
    assign timeout_abort = timeout_hit && !((state == WAIT) && bus_rsp_valid);
    assign misalign_err  = accept && !aligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        load_req      = 1'b0;
        rsp_take      = 1'b0;
        core_stall    = 1'b0;
        bus_req_valid = 1'b0;
        case (state)
            IDLE: begin
                accept = enable && core_valid;
                if (accept && aligned) begin
                    load_req   = 1'b1;
                    core_stall = 1'b1;
                    state_nxt  = REQ;
                end
            end
            REQ: begin
                core_stall    = 1'b1;
                bus_req_valid = !timeout_hit;
                if (timeout_hit) begin
                    state_nxt = DONE;
                end else if (bus_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                core_stall = 1'b1;
                if (bus_rsp_valid) begin
                    rsp_take  = 1'b1;
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_rdata <= '0;
            core_err   <= 1'b0;
        end else begin
            core_err <= misalign_err || timeout_abort;
            if (bus_req_we == MEMACC_LOAD) begin
                if (rsp_take) begin
                    core_rdata <= bus_rsp_data;
                end else if (timeout_abort) begin
                    core_rdata <= DATA_W'(TIMEOUT_DATA);
                end
            end
        end
    end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the core's memory-access stage on its data port.
- Turns the core's single-cycle access request (address, store data, type, valid) into a valid/ready request plus response-valid bus transaction toward data memory or interconnect.
- Returns load data to the core on port_data_in and raises a stall while the transaction is outstanding, so the pipeline freezes via enable.

Parameters:
- ADDR_W, 32, width of address path
- DATA_W, 32, width of data path
- TIMEOUT, 255, cycles to wait for a response before abort; used only with DMEM_TIMEOUT_EN

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- enable  input  1  gates acceptance of new core requests only
- core_addr  input  ADDR_W  from port_data_addr
- core_wdata  input  DATA_W  from port_data_out
- core_type  input  1  from port_memacc_type; 0=load, 1=store
- core_valid  input  1  from port_memacc_valid
- core_rdata  output  DATA_W  to port_data_in; load result
- core_stall  output  1  high while a transaction is pending; drives core enable low
- core_err  output  1  one-cycle pulse on misaligned access (or on timeout when the feature is built)
- bus_req_valid  output  1  request valid
- bus_req_ready  input  1  request accepted
- bus_req_we  output  1  1=write
- bus_req_addr  output  ADDR_W  word-aligned request address
- bus_req_wdata  output  DATA_W  write data
- bus_rsp_valid  input  1  response/ack valid, one-cycle pulse
- bus_rsp_data  input  DATA_W  read data, qualified by bus_rsp_valid

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset (async, any state): state=IDLE. All of the following clear immediately, including mid-transaction:
  - core_rdata=0, core_err=0
  - bus_req_valid=0, bus_req_we=0, bus_req_addr=0, bus_req_wdata=0
  - Any in-flight transaction is dropped; a late bus_rsp_valid after reset is ignored in IDLE.
- IDLE:
  - Accept when enable && core_valid.
  - If core_addr[1:0]!=0: no bus activity; core_err pulses high the next cycle; stay IDLE.
  - Otherwise capture addr, wdata and type into registers; go to REQ.
- core_stall (combinational) = (IDLE && enable && core_valid && aligned) || REQ || WAIT.
  - The stall is therefore high in the accept cycle, so the core holds its request.
  - core_stall is low in DONE and IDLE.
- REQ:
  - bus_req_valid=1 with registered we/addr/wdata; these stay stable until bus_req_ready.
  - On bus_req_valid && bus_req_ready go to WAIT.
  - bus_rsp_valid in REQ is ignored.
- WAIT:
  - On bus_rsp_valid go to DONE.
  - For loads, core_rdata <= bus_rsp_data. For stores, core_rdata is unchanged.
- DONE: one cycle, then IDLE. Requests are not accepted in DONE; the next accept occurs in IDLE.
- core_rdata holds its last load value until the next load completes.
- Minimum latency with ready=1 and an immediate response: accept at cycle 0, REQ at 1, WAIT at 2, DONE at 3. Stall is high for cycles 0-2.
- enable=0 during REQ/WAIT has no effect; an in-flight transaction always completes.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- With the macro defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to REQ and increments each cycle in REQ or WAIT.
  - On reaching TIMEOUT: drop bus_req_valid, set core_rdata=32'hDEAD_BEEF for loads, pulse core_err, and go to DONE.
  - A simultaneous response in the timeout cycle wins: normal completion, no error.
- Without the macro: no counter; the bridge waits indefinitely.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DONE=2'd3
  - MEMACC_LOAD/MEMACC_STORE constants
  - TIMEOUT_DATA constant (32'hDEAD_BEEF)
- One sub-module is natural: dmem_req_reg, the capture register for addr, wdata and we with a load enable.
- Everything else stays flat.

Test Plan:
- Load, ready=1, rsp next cycle with data 32'h1234_5678, addr 32'h100 -> bus_req_addr=32'h100, we=0; core_rdata=32'h1234_5678 in DONE (cycle 3); stall high for exactly cycles 0-2.
- Store to 32'h204 with wdata 32'hCAFE_F00D, ready low 4 cycles -> bus_req_valid held 5 cycles with stable addr/wdata; core_rdata unchanged after ack.
- Misaligned load at 32'h102 -> no bus_req_valid, core_err pulses 1 cycle, stall never asserted.
- Async rst asserted in WAIT -> bus_req_valid=0 and all outputs zero immediately; a later bus_rsp_valid is ignored and state stays IDLE.
- core_valid with enable=0 -> no accept. enable dropped during WAIT -> the transaction still completes.
- DMEM_TIMEOUT_EN, TIMEOUT=8, no response -> after 8 cycles core_err pulses and core_rdata=32'hDEAD_BEEF. A response on the 8th cycle instead -> normal data, no error.
